// File: rtl/pipe_shifter.sv
// ---------------------------------------------------------------------------
// pipe_shifter
//
// Pipelined barrel shifter with valid/ready handshaking on both sides.
// The shift is split into AMT_W stages: stage k shifts by 2^(AMT_W-1-k)
// when amount bit AMT_W-1-k is set, so the largest shift happens first.
// Every stage is a register slice with its own valid bit. Bubbles collapse
// and a full pipeline sustains one operation per cycle.
//
// Modes (in_mode):
//   00 SLL  logical left, zeros enter at the LSB end
//   01 SRL  logical right, zeros enter at the MSB end
//   10 SRA  arithmetic right, the operand's sign bit enters at the MSB end
//   11 ROL  rotate left when PIPE_SHIFTER_ROTATE_EN is defined,
//           otherwise identical to SLL
//
// Configuration macro:
//   PIPE_SHIFTER_ROTATE_EN  enables the rotate wrap path for mode 11
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high reset, flushes every stage
//   in_valid   operand offered
//   in_ready   operand accepted when in_valid & in_ready
//   in_data    operand (WIDTH bits)
//   in_amt     shift amount (AMT_W bits)
//   in_mode    shift mode (2 bits)
//   out_valid  result present
//   out_ready  consumer accepts when out_valid & out_ready
//   out_data   shifted result, forced to 0 while out_valid is low
//   out_zero   high when out_data is zero
// ---------------------------------------------------------------------------
module pipe_shifter #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROL = 2'b11
    } mode_e;

    localparam int LAST = AMT_W - 1;

    // Stage registers. The final stage has no amount or mode left to carry,
    // so those arrays stop one stage short.
    logic [WIDTH-1:0] data_q  [AMT_W];
    logic [AMT_W-1:0] valid_q;
    logic [AMT_W-1:0] amt_q   [AMT_W-1];
    logic [1:0]       mode_q  [AMT_W-1];

    // Inputs presented to each stage, its shifted data and its load enable.
    logic [WIDTH-1:0] src_data  [AMT_W];
    logic [AMT_W-1:0] src_amt   [AMT_W];
    logic [1:0]       src_mode  [AMT_W];
    logic [AMT_W-1:0] src_valid;
    logic [WIDTH-1:0] shifted   [AMT_W];
    logic [AMT_W-1:0] stage_ready;
    logic             chain;

    // One conditional shift step by a fixed distance. For SRA the data MSB
    // still equals the original sign bit, because every earlier step
    // preserved it, so it serves as the fill bit.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input int               sh
    );
        logic [WIDTH-1:0] r;
        case (mode)
            MODE_SRL: r = d >> sh;
            MODE_SRA: r = $signed(d) >>> sh;
`ifdef PIPE_SHIFTER_ROTATE_EN
            MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
`endif
            default:  r = d << sh;
        endcase
        return r;
    endfunction

    // Stage 0 is fed from the input port and every later stage from its
    // predecessor's registers.
    always_comb begin
        src_data[0]  = in_data;
        src_amt[0]   = in_amt;
        src_mode[0]  = in_mode;
        src_valid[0] = in_valid;
        for (int k = 1; k < AMT_W; k++) begin
            src_data[k]  = data_q[k-1];
            src_amt[k]   = amt_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
    end

    // The remaining amount is shifted left after every stage, so the MSB of
    // a stage's incoming amount is always that stage's control bit.
    always_comb begin
        for (int k = 0; k < AMT_W; k++) begin
            shifted[k] = src_amt[k][AMT_W-1]
                       ? shift_step(src_data[k], src_mode[k], 1 << (AMT_W - 1 - k))
                       : src_data[k];
        end
    end

    // Ready chain from the output back to the input. A stage can load when
    // it is empty or when its contents leave in the same cycle. The chain is
    // built through a temporary so that no bit of stage_ready reads another.
    always_comb begin
        stage_ready = '0;
        chain       = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            stage_ready[k] = ~valid_q[k] | chain;
            chain          = stage_ready[k];
        end
    end

    assign in_ready = stage_ready[0];

    // Stage registers. The valid bit follows the predecessor on every load
    // so that a bubble propagates. The payload only updates with a real
    // operand, which keeps idle-cycle input values out of the pipeline.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int k = 0; k < AMT_W; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < AMT_W - 1; k++) begin
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < AMT_W; k++) begin
                if (stage_ready[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k] <= shifted[k];
                    end
                end
            end
            for (int k = 0; k < AMT_W - 1; k++) begin
                if (stage_ready[k] && src_valid[k]) begin
                    amt_q[k]  <= src_amt[k] << 1;
                    mode_q[k] <= src_mode[k];
                end
            end
        end
    end

    // Output is gated by the last valid bit, so stale payload never shows.
    // The zero flag is derived from the same gated value.
    assign out_valid = valid_q[LAST];
    assign out_data  = valid_q[LAST] ? data_q[LAST] : '0;
    assign out_zero  = (out_data == '0);

endmodule
